max_exp_collect: RTL and testbench

MAX_EXP_COLLECT -- requirements
Module: max_exp_collect

---
 rtl/mac_pkg.sv | 26 ++
 rtl/max_exp_collect.sv | 152 +++++++++++++++
 tb/tb_max_exp_collect.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mac_pkg
//  Description : Shared widths, group size and FSM state encoding for the
//                partial-product maximum-exponent collector.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    // Exponent width of each product.
    localparam int EXP_W = 6;

    // Denormalised partial-product width: {sign, leading digit, 2 fraction}.
    localparam int PP_W  = 4;

    // Maximum number of partial products sharing one alignment exponent.
    localparam int GROUP = 8;

    // Collector phases: FILL gathers a group, DRAIN streams it to the aligner.
    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/max_exp_collect.sv
`default_nettype none
// ============================================================================
//  Module      : max_exp_collect
//  Description : Buffers up to GROUP {exponent, partial product} entries,
//                tracks the group's maximum exponent while filling, then
//                replays the entries alongside that maximum so a downstream
//                aligner can shift every product against a common exponent.
//  Revision    : 1.0 - initial release
// ============================================================================
module max_exp_collect #(
    parameter int GROUP = mac_pkg::GROUP,
    parameter int EXP_W = mac_pkg::EXP_W,
    parameter int PP_W  = mac_pkg::PP_W
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [PP_W-1:0]  in_pp,
    input  logic             in_last,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] out_exp,
    output logic [PP_W-1:0]  out_pp,
    output logic [EXP_W-1:0] out_max_exp,
    output logic             out_last
);

    import mac_pkg::*;

    // Counters must be able to hold the full group size, the buffer index
    // only needs to address GROUP slots.
    localparam int              CNT_W     = $clog2(GROUP + 1);
    localparam int              IDX_W     = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam int              ENT_W     = EXP_W + PP_W;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(GROUP - 1);

    state_t             state;
    state_t             state_next;

    logic [CNT_W-1:0]   wr_cnt;
    logic [CNT_W-1:0]   rd_cnt;
    logic [CNT_W-1:0]   count;
    logic [EXP_W-1:0]   max_exp;

    logic [ENT_W-1:0]   entry_buf [GROUP];
    logic [ENT_W-1:0]   rd_entry;

    logic               accept;
    logic               close_grp;
    logic               take;
    logic               at_last;
    logic               drain_done;

    // Handshake qualifiers; in_last only matters on an accepted entry.
    assign accept     = in_valid && (state == FILL);
    assign close_grp  = accept && (in_last || (wr_cnt == LAST_SLOT));
    assign take       = (state == DRAIN) && out_ready;
    assign at_last    = (rd_cnt == (count - 1'b1));
    assign drain_done = take && at_last;
    assign rd_entry   = entry_buf[rd_cnt[IDX_W-1:0]];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: close a group on its final accept, reopen after the last
    // entry has been consumed.
    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (close_grp)  state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = FILL;
            default:                 state_next = FILL;
        endcase
    end

    // Outputs: data is only presented while draining and is zero otherwise.
    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_exp     = '0;
        out_pp      = '0;
        out_max_exp = '0;
        out_last    = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
            end
            DRAIN: begin
                out_valid   = 1'b1;
                out_exp     = rd_entry[ENT_W-1:PP_W];
                out_pp      = rd_entry[PP_W-1:0];
                out_max_exp = max_exp;
                out_last    = at_last;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Write/read pointers, group length and the running maximum exponent.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            count   <= '0;
            max_exp <= '0;
        end else begin
            if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                // First entry seeds the max; later ones replace it only when
                // strictly larger, so ties keep the earlier value.
                if (wr_cnt == '0) begin
                    max_exp <= in_exp;
                end else if (in_exp > max_exp) begin
                    max_exp <= in_exp;
                end
                if (close_grp) begin
                    count  <= wr_cnt + 1'b1;
                    rd_cnt <= '0;
                end
            end
            if (drain_done) begin
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                count   <= '0;
                max_exp <= '0;
            end else if (take) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            entry_buf[wr_cnt[IDX_W-1:0]] <= {in_exp, in_pp};
        end
    end

endmodule : max_exp_collect
`default_nettype wire

// File: tb/tb_max_exp_collect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_max_exp_collect
//  Description : Self-checking bench for max_exp_collect. A stimulus thread
//                sends groups and pushes the expected drain sequence into a
//                scoreboard; a monitor pops and compares on every output
//                handshake and checks idle/stall behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_max_exp_collect;

    localparam int GROUP = 8;
    localparam int EXP_W = 6;
    localparam int PP_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] in_exp;
    logic [PP_W-1:0]  in_pp;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] out_exp;
    logic [PP_W-1:0]  out_pp;
    logic [EXP_W-1:0] out_max_exp;
    logic             out_last;

    max_exp_collect #(
        .GROUP (GROUP),
        .EXP_W (EXP_W),
        .PP_W  (PP_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_exp      (in_exp),
        .in_pp       (in_pp),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_exp     (out_exp),
        .out_pp      (out_pp),
        .out_max_exp (out_max_exp),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [EXP_W-1:0] e;
        logic [PP_W-1:0]  p;
        logic [EXP_W-1:0] m;
        logic             l;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_pop = 0;

    // Current group under construction by the stimulus thread.
    logic [EXP_W-1:0] g_exp [GROUP];
    logic [PP_W-1:0]  g_pp  [GROUP];
    int               g_n;
    bit               g_last;

    // out_ready pattern: 0 always ready, 1 random, 2 fixed 1,0,0,1 cycle.
    int rmode = 0;
    int pidx  = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the group maximum is simply the largest exponent sent, and
    // every entry comes back in order with last flagged on the final one.
    task automatic push_expected();
        logic [EXP_W-1:0] mx;
        exp_t             x;
        mx = '0;
        for (int i = 0; i < g_n; i++)
            if (g_exp[i] > mx) mx = g_exp[i];
        for (int i = 0; i < g_n; i++) begin
            x.e = g_exp[i];
            x.p = g_pp[i];
            x.m = mx;
            x.l = (i == g_n - 1);
            sb.push_back(x);
        end
    endtask

    task automatic send_group(input bit hold_valid, input bit rand_gaps);
        bit acc;
        for (int i = 0; i < g_n; i++) begin
            if (rand_gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom_range(0, 1));
                in_exp   = 6'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_exp   = g_exp[i];
            in_pp    = g_pp[i];
            in_last  = (i == g_n - 1) && g_last;
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
            end
            if (!acc) begin
                check("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            if (i == g_n - 1) push_expected();
        end
        if (!hold_valid) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            done = (sb.size() == 0) && in_ready && !out_valid;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    // out_ready driver.
    always @(posedge clk) begin
        #1;
        case (rmode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2: begin
                out_ready = pat[pidx];
                pidx      = (pidx + 1) % 4;
            end
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor: compares every consumed entry and checks idle/stall behaviour.
    bit   stall    = 1'b0;
    bit   exp_fill = 1'b0;
    exp_t held;
    exp_t cur;
    exp_t want;
    always @(negedge clk) begin
        if (rst) begin
            stall    = 1'b0;
            exp_fill = 1'b0;
        end else begin
            cur = {out_exp, out_pp, out_max_exp, out_last};
            if (exp_fill) begin
                check("refill_in_ready", 32'(in_ready), 32'd1);
                check("refill_out_valid", 32'(out_valid), 32'd0);
                exp_fill = 1'b0;
            end
            if (!out_valid) begin
                check("fill_in_ready", 32'(in_ready), 32'd1);
                check("fill_outputs_zero", 32'(cur), 32'd0);
            end else begin
                check("drain_in_ready", 32'(in_ready), 32'd0);
                if (stall) check("stall_hold", 32'(cur), 32'(held));
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 32'(cur), 32'd0 - 32'd1);
                    end else begin
                        want = sb.pop_front();
                        check("out_entry", 32'(cur), 32'(want));
                        n_pop++;
                        if (out_last) exp_fill = 1'b1;
                    end
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    held  = cur;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit hv;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_exp    = '0;
        in_pp     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs_zero", {out_exp, out_pp, out_max_exp, out_last}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full group closed by count.
        g_exp = '{6'd3, 6'd7, 6'd2, 6'd7, 6'd1, 6'd0, 6'd5, 6'd4};
        for (int i = 0; i < GROUP; i++) g_pp[i] = 4'h5;
        g_n = 8; g_last = 1'b0;
        send_group(1'b0, 1'b0);
        wait_drain();

        // Early close on in_last.
        g_exp[0] = 6'd10; g_exp[1] = 6'd12; g_exp[2] = 6'd9;
        g_pp[0] = 4'h1;   g_pp[1] = 4'h2;   g_pp[2] = 4'h3;
        g_n = 3; g_last = 1'b1;
        send_group(1'b0, 1'b0);
        wait_drain();

        // Backpressure with a 1,0,0,1 ready pattern.
        rmode = 2; pidx = 0;
        for (int i = 0; i < GROUP; i++) begin
            g_exp[i] = 6'($urandom);
            g_pp[i]  = 4'($urandom);
        end
        g_n = 8; g_last = 1'b0;
        send_group(1'b0, 1'b0);
        wait_drain();
        rmode = 0;

        // Single-entry group at the top of the exponent range.
        g_exp[0] = 6'd63; g_pp[0] = 4'hF;
        g_n = 1; g_last = 1'b1;
        send_group(1'b0, 1'b0);
        wait_drain();

        // Reset after two of eight outputs have drained.
        for (int i = 0; i < GROUP; i++) begin
            g_exp[i] = 6'($urandom_range(40, 63));
            g_pp[i]  = 4'($urandom);
        end
        g_n = 8; g_last = 1'b0;
        base = n_pop;
        send_group(1'b0, 1'b0);
        for (int t = 0; t < 50 && (n_pop - base) < 2; t++) begin
            @(posedge clk); #1;
        end
        check("pre_reset_pops", 32'(n_pop - base), 32'd2);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_reset_out_valid", 32'(out_valid), 32'd0);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        g_exp[0] = 6'd1; g_exp[1] = 6'd2;
        g_pp[0] = 4'h6;  g_pp[1] = 4'h7;
        g_n = 2; g_last = 1'b1;
        send_group(1'b0, 1'b0);
        wait_drain();

        // Back-to-back groups with in_valid held high.
        g_exp[0] = 6'd9; g_exp[1] = 6'd3; g_exp[2] = 6'd1;
        g_pp[0] = 4'h8;  g_pp[1] = 4'h9;  g_pp[2] = 4'hA;
        g_n = 3; g_last = 1'b1;
        send_group(1'b1, 1'b0);
        g_exp[0] = 6'd4; g_exp[1] = 6'd2;
        g_pp[0] = 4'hB;  g_pp[1] = 4'hC;
        g_n = 2; g_last = 1'b1;
        send_group(1'b0, 1'b0);
        wait_drain();

        // Randomized groups, gaps and backpressure.
        rmode = 1;
        for (int k = 0; k < 25; k++) begin
            g_n    = $urandom_range(1, GROUP);
            g_last = (g_n < GROUP) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < GROUP; i++) begin
                g_exp[i] = 6'($urandom);
                g_pp[i]  = 4'($urandom);
            end
            hv = 1'($urandom_range(0, 1));
            send_group(hv, 1'b1);
            if (!hv) wait_drain();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_drain();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_max_exp_collect
`default_nettype wire
